// File: rtl/pattern_wavegen.sv
// rtl/pattern_wavegen.sv - programmable serial waveform generator
// Pattern memory words are shifted out LSB first, each bit held div+1 clocks, in loop or one-shot mode.
module pattern_wavegen #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     mode,
    input  logic [$clog2(DEPTH)-1:0] last_addr,
    input  logic [DIV_W-1:0]         div,
    output logic                     wform,
    output logic                     busy,
    output logic                     done,
    output logic                     bit_tick
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              cfg_mode;
    logic [AW-1:0]     cfg_last;
    logic [DIV_W-1:0]  cfg_div;
    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     bit_idx;
    logic [AW-1:0]     addr;
    logic [DIV_W-1:0]  cnt;

    logic              term, bit_end, word_end;
    logic              go, halt, finish, next_word, next_bit;
    logic [AW-1:0]     addr_sel;
    logic [WIDTH-1:0]  load_word;
    logic              wform_next, done_next, tick_next;

    // Memory has no reset; a load on the same edge as a write sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign term      = (cnt == cfg_div);
    assign bit_end   = term && (bit_idx == BW'(WIDTH - 1));
    assign word_end  = (addr == cfg_last);
    assign addr_sel  = (go || word_end) ? '0 : addr + AW'(1);
    assign load_word = mem[addr_sel];

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        go         = 1'b0;
        halt       = 1'b0;
        finish     = 1'b0;
        next_word  = 1'b0;
        next_bit   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next = RUN;
                    go         = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                    halt       = 1'b1;
                end else if (bit_end && word_end && cfg_mode) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end else if (bit_end) begin
                    next_word = 1'b1;
                end else if (term) begin
                    next_bit = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == RUN);
        wform_next = wform;
        tick_next  = 1'b0;
        done_next  = 1'b0;
        if (go || next_word) begin
            wform_next = load_word[0];
            tick_next  = 1'b1;
        end else if (next_bit) begin
            wform_next = shreg[bit_idx + BW'(1)];
            tick_next  = 1'b1;
        end else if (halt || finish) begin
            wform_next = 1'b0;
            done_next  = finish;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cfg_mode <= 1'b0;
            cfg_last <= '0;
            cfg_div  <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            addr     <= '0;
            cnt      <= '0;
            wform    <= 1'b0;
            done     <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            wform    <= wform_next;
            done     <= done_next;
            bit_tick <= tick_next;
            if (go) begin
                cfg_mode <= mode;
                cfg_last <= last_addr;
                cfg_div  <= div;
            end
            if (go || next_word) begin
                shreg   <= load_word;
                addr    <= addr_sel;
                bit_idx <= '0;
                cnt     <= '0;
            end else if (next_bit) begin
                bit_idx <= bit_idx + BW'(1);
                cnt     <= '0;
            end else if (halt || finish) begin
                bit_idx <= '0;
                addr    <= '0;
                cnt     <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pattern_wavegen.sv
// tb/tb_pattern_wavegen.sv - randomized self-checking bench for pattern_wavegen
// Expected outputs come from a cycle-index model: bit position = n/(div+1), word = bit/WIDTH.
module tb_pattern_wavegen;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] div = '0;
    logic          wform, busy, done, bit_tick;

    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  model_mem [D];
    logic [3:0]    act_q [$];
    logic [3:0]    exp_q [$];

    always #5 clk = ~clk;

    pattern_wavegen #(.WIDTH(W), .DEPTH(D), .DIV_W(DW)) dut (
        .clk(clk), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .mode(mode), .last_addr(last_addr), .div(div),
        .wform(wform), .busy(busy), .done(done), .bit_tick(bit_tick)
    );

    task automatic write_word(input int a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    // Starts playback from the current config inputs and records ncyc cycles of {wform,busy,done,bit_tick}.
    task automatic run_play(input int ncyc, input bit hold, input bit do_wr, input int wr_cyc,
                            input int wa, input logic [W-1:0] wd);
        int dv, lst, per_word, pass_len, p;
        bit md;
        logic [W-1:0] cur;
        logic [3:0] e;
        dv = int'(div); lst = int'(last_addr); md = mode;
        per_word = W * (dv + 1); pass_len = (lst + 1) * per_word;
        act_q.delete(); exp_q.delete(); cur = '0;
        start = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            wr_en = do_wr && (n == wr_cyc);
            if (wr_en) begin wr_addr = AW'(wa); wr_data = wd; end
            if (n == 1) begin
                start = hold;
                div = DW'($urandom_range(0, 7));
                mode = 1'($urandom);
                last_addr = AW'($urandom);
            end
            if (md && n >= pass_len) begin
                e = {1'b0, 1'b0, n == pass_len, 1'b0};
            end else begin
                p = n % pass_len;
                if (p % per_word == 0) cur = model_mem[p / per_word];
                e = {cur[(p / (dv + 1)) % W], 1'b1, 1'b0, (p % (dv + 1)) == 0};
            end
            if (wr_en) model_mem[wa] = wd;
            @(posedge clk); @(negedge clk);
            act_q.push_back({wform, busy, done, bit_tick});
            exp_q.push_back(e);
        end
        wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({wform, busy, done, bit_tick} !== 4'b0000) begin
            fails++; $display("FAIL reset_state: got %b expected 0000", {wform, busy, done, bit_tick});
        end
        clear = 1'b0;
        write_word(0, 8'($urandom)); write_word(1, 8'($urandom));
        mode = 1'b0; last_addr = 4'd1; div = 16'd5;
        run_play(10, 1'b0, 1'b0, 0, 0, 8'h00);
        for (int i = 0; i < act_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL reset_pre cycle %0d: got %b expected %b", i, act_q[i], exp_q[i]);
            end
        end
        #2 clear = 1'b1;
        #1 tests++;
        if ({wform, busy, done, bit_tick} !== 4'b0000) begin
            fails++; $display("FAIL reset_async: got %b expected 0000", {wform, busy, done, bit_tick});
        end
        @(negedge clk); clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            tests++;
            if ({wform, busy, done, bit_tick} !== 4'b0000) begin
                fails++; $display("FAIL reset_quiet cycle %0d: got %b expected 0000", i, {wform, busy, done, bit_tick});
            end
        end
    endtask

    task automatic test_loop_basic();
        logic [15:0] pat;
        pat = 16'b1010_1010_1100_1100;
        write_word(0, 8'hCC); write_word(1, 8'hAA);
        mode = 1'b0; last_addr = 4'd1; div = 16'd0;
        run_play(40, 1'b0, 1'b0, 0, 0, 8'h00);
        for (int i = 0; i < act_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i] || act_q[i][3] !== pat[i % 16]) begin
                fails++; $display("FAIL loop_basic cycle %0d: got %b expected %b (wform %b)", i, act_q[i], exp_q[i], pat[i % 16]);
            end
        end
        stop = 1'b1; @(posedge clk); @(negedge clk); stop = 1'b0;
        tests++;
        if ({wform, busy, done, bit_tick} !== 4'b0000) begin
            fails++; $display("FAIL loop_basic_stop: got %b expected 0000", {wform, busy, done, bit_tick});
        end
    endtask

    task automatic test_oneshot();
        write_word(0, 8'h01);
        mode = 1'b1; last_addr = 4'd0; div = 16'd3;
        run_play(33, 1'b1, 1'b0, 0, 0, 8'h00);
        for (int i = 0; i < act_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL oneshot cycle %0d: got %b expected %b", i, act_q[i], exp_q[i]);
            end
        end
        tests++;
        if (act_q[32] !== 4'b0010 || act_q[3] !== 4'b1100 || act_q[4] !== 4'b0101) begin
            fails++; $display("FAIL oneshot_edges: got %b/%b/%b expected 1100/0101/0010", act_q[3], act_q[4], act_q[32]);
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if ({wform, busy, done, bit_tick} !== 4'b0000) begin
            fails++; $display("FAIL oneshot_after: got %b expected 0000", {wform, busy, done, bit_tick});
        end
    endtask

    task automatic test_stop();
        write_word(0, 8'($urandom)); write_word(1, 8'($urandom));
        mode = 1'b0; last_addr = 4'd1; div = 16'd2;
        run_play(35, 1'b0, 1'b0, 0, 0, 8'h00);
        for (int i = 0; i < act_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL stop_play cycle %0d: got %b expected %b", i, act_q[i], exp_q[i]);
            end
        end
        stop = 1'b1; @(posedge clk); @(negedge clk); stop = 1'b0;
        tests++;
        if ({wform, busy, done, bit_tick} !== 4'b0000) begin
            fails++; $display("FAIL stop_abort: got %b expected 0000", {wform, busy, done, bit_tick});
        end
        start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            tests++;
            if ({wform, busy, done, bit_tick} !== 4'b0000) begin
                fails++; $display("FAIL start_stop_idle cycle %0d: got %b expected 0000", i, {wform, busy, done, bit_tick});
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_write_during_play();
        write_word(0, 8'($urandom) & 8'h7F); write_word(1, 8'($urandom));
        mode = 1'b0; last_addr = 4'd1; div = 16'd1;
        run_play(70, 1'b0, 1'b1, 3, 0, 8'hFF);
        for (int i = 0; i < act_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i] || (i >= 32 && i < 48 && act_q[i][3] !== 1'b1)) begin
                fails++; $display("FAIL write_current cycle %0d: got %b expected %b", i, act_q[i], exp_q[i]);
            end
        end
        stop = 1'b1; @(posedge clk); @(negedge clk); stop = 1'b0;
        div = 16'd1; mode = 1'b0; last_addr = 4'd1;
        run_play(70, 1'b0, 1'b1, 16, 1, ~model_mem[1]);
        for (int i = 0; i < act_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL write_same_edge cycle %0d: got %b expected %b", i, act_q[i], exp_q[i]);
            end
        end
        stop = 1'b1; @(posedge clk); @(negedge clk); stop = 1'b0;
    endtask

    task automatic test_full_depth();
        for (int a = 0; a < D; a++) write_word(a, 8'($urandom));
        mode = 1'b0; last_addr = 4'd15; div = 16'd0;
        run_play(2 * D * W + 5, 1'b0, 1'b0, 0, 0, 8'h00);
        for (int i = 0; i < act_q.size(); i++) begin
            tests++;
            if (act_q[i] !== exp_q[i]) begin
                fails++; $display("FAIL full_depth cycle %0d: got %b expected %b", i, act_q[i], exp_q[i]);
            end
        end
        stop = 1'b1; @(posedge clk); @(negedge clk); stop = 1'b0;
    endtask

    task automatic test_random();
        int lst, dv, plen;
        for (int it = 0; it < 6; it++) begin
            lst = $urandom_range(0, 3); dv = $urandom_range(0, 3);
            for (int a = 0; a <= lst; a++) write_word(a, 8'($urandom));
            mode = 1'($urandom); last_addr = AW'(lst); div = DW'(dv);
            plen = (lst + 1) * W * (dv + 1);
            run_play(mode ? plen + 3 : 2 * plen + 5, 1'b0, 1'b1, $urandom_range(0, plen),
                     $urandom_range(0, lst), 8'($urandom));
            for (int i = 0; i < act_q.size(); i++) begin
                tests++;
                if (act_q[i] !== exp_q[i]) begin
                    fails++; $display("FAIL random it%0d cycle %0d: got %b expected %b", it, i, act_q[i], exp_q[i]);
                end
            end
            stop = 1'b1; @(posedge clk); @(negedge clk); stop = 1'b0;
            tests++;
            if ({wform, busy, done, bit_tick} !== 4'b0000) begin
                fails++; $display("FAIL random_end it%0d: got %b expected 0000", it, {wform, busy, done, bit_tick});
            end
        end
    endtask

    initial begin
        test_reset();
        test_loop_basic();
        test_oneshot();
        test_stop();
        test_write_during_play();
        test_full_depth();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
